// File: rtl/led_pwm_monitor.sv
// led_pwm_monitor: receive-side decoder for the 8-bit one-hot PWM LED bus.
// Locks onto the first PWM rising edge, then measures back-to-back windows
// of WINDOW cycles. For each window it reports the on-time, the lit LED, the
// duty trend against the previous lit window, and one-hot/stability errors.
module led_pwm_monitor #(
  parameter int WINDOW = 501,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       led_in,
  output logic             sample_valid,
  output logic [CNT_W-1:0] duty_out,
  output logic [2:0]       led_idx,
  output logic [1:0]       dir,
  output logic             dark,
  output logic             multi_err,
  output logic             led_step
);

  typedef enum logic {
    SYNC,
    MEASURE
  } state_e;

  localparam logic [1:0] DIR_EQ   = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW - 1);

  // Index of the lowest set bit; 0 when the bus is dark.
  function automatic logic [2:0] lowest_bit(input logic [7:0] v);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_bit = 3'(i);
    end
  endfunction

  state_e           state_q, state_d;
  logic             prev_led_q, prev_led_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [2:0]       first_idx_q, first_idx_d;
  logic             first_vld_q, first_vld_d;
  logic             err_acc_q, err_acc_d;
  logic             hist_vld_q, hist_vld_d;
  logic [CNT_W-1:0] prev_duty_q, prev_duty_d;
  logic             sample_valid_q, sample_valid_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [2:0]       led_idx_q, led_idx_d;
  logic [1:0]       dir_q, dir_d;
  logic             dark_q, dark_d;
  logic             multi_err_q, multi_err_d;
  logic             led_step_q, led_step_d;

  logic             led_nz;
  logic             multi_bits;
  logic             rise;
  logic [2:0]       cur_idx;
  logic             sample_err;
  logic [CNT_W-1:0] hi_next;
  logic [2:0]       win_idx;

  // Per-sample decode of the bus: edge, lit LED and protocol violations.
  always_comb begin
    led_nz     = |led_in;
    // x & (x-1) clears the lowest set bit, so any residue means >1 bit lit.
    multi_bits = (led_in & (led_in - 8'd1)) != 8'd0;
    rise       = led_nz && !prev_led_q;
    cur_idx    = lowest_bit(led_in);
    sample_err = multi_bits || (first_vld_q && led_nz && (cur_idx != first_idx_q));
    hi_next    = hi_cnt_q + CNT_W'(led_nz);
    win_idx    = first_vld_q ? first_idx_q : cur_idx;
  end

  // Next-state logic: window alignment, accumulation and close-out results.
  always_comb begin
    // NOTE: every _d starts from its hold value so no path leaves it unassigned
    // (an unassigned path in combinational logic infers a latch).
    state_d        = state_q;
    prev_led_d     = led_nz;
    win_cnt_d      = win_cnt_q;
    hi_cnt_d       = hi_cnt_q;
    first_idx_d    = first_idx_q;
    first_vld_d    = first_vld_q;
    err_acc_d      = err_acc_q;
    hist_vld_d     = hist_vld_q;
    prev_duty_d    = prev_duty_q;
    sample_valid_d = 1'b0;
    duty_d         = duty_q;
    led_idx_d      = led_idx_q;
    dir_d          = dir_q;
    dark_d         = dark_q;
    multi_err_d    = multi_err_q;
    led_step_d     = 1'b0;

    unique case (state_q)
      SYNC: begin
        // The rising-edge cycle itself is sample 0 of the first window.
        if (rise) begin
          win_cnt_d   = CNT_W'(1);
          hi_cnt_d    = CNT_W'(1);
          first_idx_d = cur_idx;
          first_vld_d = 1'b1;
          err_acc_d   = multi_bits;
          state_d     = MEASURE;
        end
      end

      MEASURE: begin
        if (win_cnt_q != LAST_SAMPLE) begin
          win_cnt_d = win_cnt_q + CNT_W'(1);
          hi_cnt_d  = hi_next;
          err_acc_d = err_acc_q | sample_err;
          if (!first_vld_q && led_nz) begin
            first_idx_d = cur_idx;
            first_vld_d = 1'b1;
          end
        end else begin
          // Last sample of the window: publish results and restart with no gap.
          sample_valid_d = 1'b1;
          duty_d         = hi_next;
          multi_err_d    = err_acc_q | sample_err;
          dark_d         = (hi_next == '0);
          win_cnt_d      = '0;
          hi_cnt_d       = '0;
          err_acc_d      = 1'b0;
          first_vld_d    = 1'b0;
          if (hi_next == '0) begin
            // A dark window means the PWM stream is gone: realign on the next edge.
            dir_d      = DIR_EQ;
            hist_vld_d = 1'b0;
            state_d    = SYNC;
          end else begin
            led_idx_d   = win_idx;
            led_step_d  = hist_vld_q && (win_idx != led_idx_q);
            if (!hist_vld_q)             dir_d = DIR_EQ;
            else if (hi_next > prev_duty_q) dir_d = DIR_UP;
            else if (hi_next < prev_duty_q) dir_d = DIR_DOWN;
            else                         dir_d = DIR_EQ;
            prev_duty_d = hi_next;
            hist_vld_d  = 1'b1;
          end
        end
      end

      default: state_d = SYNC;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q        <= SYNC;
      prev_led_q     <= 1'b0;
      win_cnt_q      <= '0;
      hi_cnt_q       <= '0;
      first_idx_q    <= '0;
      first_vld_q    <= 1'b0;
      err_acc_q      <= 1'b0;
      hist_vld_q     <= 1'b0;
      prev_duty_q    <= '0;
      sample_valid_q <= 1'b0;
      duty_q         <= '0;
      led_idx_q      <= '0;
      dir_q          <= DIR_EQ;
      dark_q         <= 1'b0;
      multi_err_q    <= 1'b0;
      led_step_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_led_q     <= prev_led_d;
      win_cnt_q      <= win_cnt_d;
      hi_cnt_q       <= hi_cnt_d;
      first_idx_q    <= first_idx_d;
      first_vld_q    <= first_vld_d;
      err_acc_q      <= err_acc_d;
      hist_vld_q     <= hist_vld_d;
      prev_duty_q    <= prev_duty_d;
      sample_valid_q <= sample_valid_d;
      duty_q         <= duty_d;
      led_idx_q      <= led_idx_d;
      dir_q          <= dir_d;
      dark_q         <= dark_d;
      multi_err_q    <= multi_err_d;
      led_step_q     <= led_step_d;
    end
  end

  assign sample_valid = sample_valid_q;
  assign duty_out     = duty_q;
  assign led_idx      = led_idx_q;
  assign dir          = dir_q;
  assign dark         = dark_q;
  assign multi_err    = multi_err_q;
  assign led_step     = led_step_q;

endmodule

// File: tb/tb_led_pwm_monitor.sv
// tb_led_pwm_monitor: directed bench for led_pwm_monitor with WINDOW=10.
// Inputs change 1 time unit after each rising edge; outputs are read at the
// same point, i.e. they reflect the edge that just captured the sample.
module tb_led_pwm_monitor;

  localparam int WINDOW = 10;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       led_in = 8'h00;
  logic             sample_valid;
  logic [CNT_W-1:0] duty_out;
  logic [2:0]       led_idx;
  logic [1:0]       dir;
  logic             dark;
  logic             multi_err;
  logic             led_step;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;

  led_pwm_monitor #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .led_in       (led_in),
    .sample_valid (sample_valid),
    .duty_out     (duty_out),
    .led_idx      (led_idx),
    .dir          (dir),
    .dark         (dark),
    .multi_err    (multi_err),
    .led_step     (led_step)
  );

  always #5 clk = ~clk;

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one bus sample, clock it in, count any result pulse.
  task automatic cyc(input logic [7:0] v);
    led_in = v;
    @(posedge clk);
    #1;
    if (sample_valid === 1'b1) pulses++;
  endtask

  // One full window: v for the first 'on' samples, then dark; sample bad_pos forced to 8'h05.
  task automatic run_win(input logic [7:0] v, input int on, input int bad_pos);
    pulses = 0;
    for (int i = 0; i < WINDOW; i++) begin
      if (i == WINDOW - 1) check("no_early_pulse", pulses, 0);
      cyc((i == bad_pos) ? 8'h05 : ((i < on) ? v : 8'h00));
    end
    check("win_pulse_count", pulses, 1);
    check("win_valid_last", {31'd0, sample_valid}, 1);
  endtask

  task automatic expect_out(input string name, input int duty, input int idx, input int d,
                            input int dk, input int me, input int st);
    check($sformatf("%s.duty", name),      32'(duty_out),  duty);
    check($sformatf("%s.led_idx", name),   32'(led_idx),   idx);
    check($sformatf("%s.dir", name),       32'(dir),       d);
    check($sformatf("%s.dark", name),      32'(dark),      dk);
    check($sformatf("%s.multi_err", name), 32'(multi_err), me);
    check($sformatf("%s.led_step", name),  32'(led_step),  st);
  endtask

  initial begin
    // 1: reset with a lit bus; everything must read zero.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc(8'h04);
    check("rst.valid", {31'd0, sample_valid}, 0);
    expect_out("rst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // 2: idle, then a 3-cycle pulse of LED 2 starting the first window.
    pulses = 0;
    for (int i = 0; i < 5; i++) cyc(8'h00);
    for (int i = 0; i < 3; i++) cyc(8'h04);
    for (int i = 0; i < 6; i++) cyc(8'h00);
    check("sync.no_early_pulse", pulses, 0);
    cyc(8'h00);
    check("sync.valid", {31'd0, sample_valid}, 1);
    expect_out("sync", 3, 2, 0, 0, 0, 0);

    // 3: chained windows with duty 5, 2, 2 after the first duty-3 window.
    run_win(8'h04, 5, -1);
    expect_out("dir_up", 5, 2, 1, 0, 0, 0);
    run_win(8'h04, 2, -1);
    expect_out("dir_down", 2, 2, 2, 0, 0, 0);
    run_win(8'h04, 2, -1);
    expect_out("dir_eq", 2, 2, 0, 0, 0, 0);

    // 4: two-hot sample inside a window, then a clean window.
    run_win(8'h04, 4, 1);
    expect_out("err", 4, 2, 1, 0, 1, 0);
    run_win(8'h04, 4, -1);
    expect_out("err_clear", 4, 2, 0, 0, 0, 0);

    // 5: dark window drops to SYNC; outputs hold; resync gives dir=00, no step.
    run_win(8'h00, 0, -1);
    expect_out("dark", 0, 2, 0, 1, 0, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) cyc(8'h00);
    check("dark.no_pulse", pulses, 0);
    expect_out("dark_hold", 0, 2, 0, 1, 0, 0);
    run_win(8'h08, 6, -1);
    expect_out("resync", 6, 3, 0, 0, 0, 0);

    // 6: LED changes produce steps; full-on windows; reset mid-window.
    run_win(8'h04, 3, -1);
    expect_out("step_3to2", 3, 2, 2, 0, 0, 1);
    run_win(8'h08, 5, -1);
    expect_out("step_2to3", 5, 3, 1, 0, 0, 1);
    run_win(8'h80, 10, -1);
    expect_out("full", 10, 7, 1, 0, 0, 1);
    run_win(8'h80, 10, -1);
    expect_out("full_chain", 10, 7, 0, 0, 0, 0);

    pulses = 0;
    for (int i = 0; i < 6; i++) cyc(8'h80);
    check("pre_rst.step_pulse", {31'd0, led_step}, 0);
    rst_n = 1'b0;
    cyc(8'h80);
    cyc(8'h80);
    check("mid_rst.no_pulse", pulses, 0);
    check("mid_rst.valid", {31'd0, sample_valid}, 0);
    expect_out("mid_rst", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Lit bus after reset is a fresh rising edge: new window, no history.
    pulses = 0;
    for (int i = 0; i < WINDOW - 1; i++) cyc(8'h80);
    check("post_rst.no_early_pulse", pulses, 0);
    cyc(8'h80);
    check("post_rst.valid", {31'd0, sample_valid}, 1);
    expect_out("post_rst", 10, 7, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
